// File: rtl/sync_pkg.sv
// Shared defaults and helpers for the synchronise-and-debounce block.
package sync_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DB_CYCLES_DEF   = 16;

    // Counter must hold values 0..db_cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        int unsigned w;
        w = $clog2(db_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One channel: reset-able synchroniser chain, stability counter, debounced
// level and registered rise/fall pulses.
module debounce_ch
    import sync_pkg::*;
#(
    parameter int unsigned STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter logic        INIT      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic sig_sync_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync_last;

    assign sync_last = sync_q[STAGES-1];

    // Count consecutive disagreeing cycles; any agreement discards the count.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], sig_i};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_last != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_last;
                rise_d  = sync_last;
                fall_d  = ~sync_last;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{INIT}};
            cnt_q   <= '0;
            level_q <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sig_sync_o = sync_last;
    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser/debouncer: WIDTH independent debounce_ch copies.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int unsigned       WIDTH     = 4,
    parameter int unsigned       STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned       DB_CYCLES = DB_CYCLES_DEF,
    parameter logic [WIDTH-1:0]  INIT      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_sync,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
        debounce_ch #(
            .STAGES    (STAGES),
            .DB_CYCLES (DB_CYCLES),
            .INIT      (INIT[g])
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_i      (sig[g]),
            .sig_sync_o (sig_sync[g]),
            .level_o    (level[g]),
            .rise_o     (rise[g]),
            .fall_o     (fall[g])
        );
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboarded bench for sync_debounce (WIDTH=4, STAGES=2, DB_CYCLES=4).
module tb_sync_debounce;

    localparam int unsigned W  = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned DB = 4;
    localparam logic [W-1:0] INIT_V = '0;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sig   = '0;
    logic [W-1:0] sig_sync, level, rise, fall;

    always #5 clk = ~clk;

    sync_debounce #(
        .WIDTH(W), .STAGES(ST), .DB_CYCLES(DB), .INIT(INIT_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig(sig),
        .sig_sync(sig_sync), .level(level), .rise(rise), .fall(fall)
    );

    typedef struct packed {
        logic [W-1:0] sync;
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] samp[$];
    int unsigned  edge_n = 0;
    logic [W-1:0] m_level = INIT_V;
    int           checks = 0;
    int           failures = 0;
    int           rise_cnt[W];
    int           fall_cnt[W];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // sig_sync seen after edge e is the input sampled STAGES-1 edges earlier.
    function automatic logic [W-1:0] sync_after(input int unsigned e);
        if (e >= ST) return samp[e - ST];
        return INIT_V;
    endfunction

    // Reference: level flips once DB consecutive edges saw sig_sync != level.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                samp.delete();
                sb.delete();
                edge_n  = 0;
                m_level = INIT_V;
            end else begin
                exp_t         x;
                logic [W-1:0] s;
                bit           all;
                samp.push_back(sig);
                edge_n++;
                x.rise = '0;
                x.fall = '0;
                for (int c = 0; c < int'(W); c++) begin
                    if (edge_n >= DB) begin
                        all = 1'b1;
                        for (int unsigned j = edge_n - DB + 1; j <= edge_n; j++) begin
                            s = sync_after(j - 1);
                            if (s[c] == m_level[c]) all = 1'b0;
                        end
                        if (all) begin
                            m_level[c] = ~m_level[c];
                            if (m_level[c]) x.rise[c] = 1'b1;
                            else            x.fall[c] = 1'b1;
                        end
                    end
                end
                x.sync  = sync_after(edge_n);
                x.level = m_level;
                sb.push_back(x);
            end
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("mon_sync",  sig_sync, x.sync);
                chk("mon_level", level,    x.level);
                chk("mon_rise",  rise,     x.rise);
                chk("mon_fall",  fall,     x.fall);
            end else if (!rst_n) begin
                chk("rst_sync",  sig_sync, INIT_V);
                chk("rst_level", level,    INIT_V);
                chk("rst_rise",  rise,     '0);
                chk("rst_fall",  fall,     '0);
            end
            chk("mon_excl", rise & fall, '0);
            for (int c = 0; c < int'(W); c++) begin
                if (rise[c] === 1'b1) rise_cnt[c]++;
                if (fall[c] === 1'b1) fall_cnt[c]++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < int'(W); c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
    endtask

    int hold[W];
    int rst_left;

    initial begin
        clr_cnt();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();

        // Single clean rise on channel 0
        clr_cnt();
        sig[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("r030_sync0",  W'(sig_sync[0]), W'(k >= 2));
            chk("r030_level0", W'(level[0]),    W'(k >= 6));
            chk("r030_rise0",  W'(rise[0]),     W'(k == 6));
        end
        chk_int("r030_rise_cnt0", rise_cnt[0], 1);
        for (int c = 1; c < int'(W); c++) chk_int("r030_other_rise", rise_cnt[c], 0);
        for (int c = 0; c < int'(W); c++) chk_int("r030_other_fall", fall_cnt[c], 0);

        // 3-cycle glitch on channel 1
        clr_cnt();
        sig[1] = 1'b1;
        repeat (3) step();
        sig[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("r031_level1", W'(level[1]), '0);
        end
        chk_int("r031_rise1", rise_cnt[1], 0);
        chk_int("r031_fall1", fall_cnt[1], 0);

        // Bounce channel 2 then settle high
        clr_cnt();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) sig[2] = ~sig[2];
            step();
        end
        sig[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("r032_rise2", W'(rise[2]), W'(k == 6));
        end
        chk_int("r032_rise_cnt2", rise_cnt[2], 1);
        chk_int("r032_fall_cnt2", fall_cnt[2], 0);

        // Reset in the middle of a count on channel 3
        clr_cnt();
        sig[3] = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("r033_level3", W'(level[3]), '0);
        chk("r033_rise3",  W'(rise[3]),  '0);
        repeat (2) step();
        chk_int("r033_rst_rise3", rise_cnt[3], 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("r033_post_rise3",  W'(rise[3]),  W'(k == 6));
            chk("r033_post_level3", W'(level[3]), W'(k >= 6));
        end

        // Simultaneous rise and fall on channels 0 and 2
        sig = '0;
        repeat (10) step();
        chk("r034_idle", level, '0);
        sig = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("r034_rise", rise, (k == 6) ? 4'b0101 : 4'b0000);
        end
        sig = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("r034_fall", fall, (k == 6) ? 4'b0101 : 4'b0000);
        end

        // Asynchronous reset takes effect between edges
        sig = '1;
        repeat (10) step();
        chk("r029_pre_level", level, '1);
        rst_n = 1'b0;
        #1;
        chk("r029_sync",  sig_sync, '0);
        chk("r029_level", level,    '0);
        chk("r029_rise",  rise,     '0);
        chk("r029_fall",  fall,     '0);
        repeat (2) step();
        rst_n = 1'b1;

        // Randomised bouncing with occasional resets
        for (int c = 0; c < int'(W); c++) hold[c] = $urandom_range(1, 9);
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < int'(W); c++) begin
                if (hold[c] == 0) begin
                    sig[c]  = ~sig[c];
                    hold[c] = $urandom_range(1, 9);
                end else begin
                    hold[c]--;
                end
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n    = 1'b0;
                rst_left = 2;
            end
            step();
        end
        rst_n = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of independent asynchronous input channels, at least 1.
REQ-002 Parameter STAGES, default 2: synchroniser flip-flop depth per channel, at least 2.
REQ-003 Parameter DB_CYCLES, default 16: consecutive stable cycles required before the debounced level changes, at least 1.
REQ-004 Parameter INIT, default all-zero, WIDTH bits: per-channel reset value of the synchroniser chain and the debounced level.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 sig  input  WIDTH  raw asynchronous inputs (buttons, switches).
REQ-008 sig_sync  output  WIDTH  last synchroniser stage per channel, not debounced.
REQ-009 level  output  WIDTH  debounced, synchronised level per channel.
REQ-010 rise  output  WIDTH  one-cycle pulse when level goes 0 to 1.
REQ-011 fall  output  WIDTH  one-cycle pulse when level goes 1 to 0.

Function
REQ-012 Each channel SHALL pass sig through a chain of STAGES flip-flops; sig_sync is the last stage, so latency from a sampled input to sig_sync is exactly STAGES edges.
REQ-013 Each channel SHALL hold a counter of width clog2(DB_CYCLES+1) that is cleared on every edge where sig_sync equals level.
REQ-014 On an edge where sig_sync differs from level and the counter is below DB_CYCLES-1, the counter SHALL increment.
REQ-015 On an edge where sig_sync differs from level and the counter equals DB_CYCLES-1, level SHALL take the value of sig_sync and the counter SHALL clear.
REQ-016 Total latency from a stable input change to level SHALL be STAGES+DB_CYCLES edges. With DB_CYCLES=1, level follows sig_sync one edge later.
REQ-017 Any return of sig_sync to the current level before the threshold SHALL discard the count, so a glitch shorter than DB_CYCLES cycles never changes level.
REQ-018 rise and fall SHALL be registered and asserted for exactly the one cycle after the edge on which level changes, coincident with the first cycle the new level is visible.
REQ-019 rise and fall of the same channel SHALL never be high together.
REQ-020 A channel held bouncing indefinitely SHALL keep level unchanged and produce no pulses.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-023 While rst_n is low, all synchroniser stages and level SHALL equal INIT, counters SHALL be 0, and rise and fall SHALL be 0, without waiting for clk.
REQ-024 Reset asserted mid-count SHALL discard the count and SHALL NOT produce a pulse on or after release.
REQ-025 After rst_n release, the first pulse SHALL require a full STAGES+DB_CYCLES stable period.

Structure
REQ-026 Package sync_pkg SHALL hold the default constants SYNC_STAGES_DEF=2 and DB_CYCLES_DEF=16 and a function for counter width.
REQ-027 A single per-channel sub-module, debounce_ch, SHALL implement the chain, counter, level and pulses for one channel; sync_debounce SHALL instantiate WIDTH copies of it using a generate loop.
REQ-028 The existing reset-less flip-flop cell SHALL NOT be reused, because every stage requires the asynchronous reset.

Verification (WIDTH=4, STAGES=2, DB_CYCLES=4, INIT=0)
REQ-029 Bench SHALL drive rst_n low between clock edges and check that all outputs are 0 immediately, before the next clk edge.
REQ-030 Bench SHALL set sig[0] from 0 to 1 and hold it, then check sig_sync[0]=1 after edge 2, level[0]=1 and rise[0]=1 for exactly one cycle after edge 6, and no other channel changes.
REQ-031 Bench SHALL drive a 3-cycle high glitch on sig[1] and check that level[1], rise[1] and fall[1] stay 0 throughout.
REQ-032 Bench SHALL toggle sig[2] every 2 cycles for 20 cycles, then hold it at 1, and check exactly one rise[2] pulse, 6 edges after the final transition.
REQ-033 Bench SHALL assert rst_n after sig[3] has been stable high for 3 cycles past sig_sync (counter=3) and check that level[3]=0 and no pulse occurs; after release with sig[3] still high, rise[3] SHALL occur 6 edges later.
REQ-034 Bench SHALL raise sig[0] and sig[2] together and later lower them together, and check that rise[0] and rise[2] pulse in the same cycle, then fall[0] and fall[2] pulse in the same cycle.
